// File: rtl/sha_pkg.sv
// sha_pkg: shared widths, result mask and scheduler state encoding for the SHA engine front-end
package sha_pkg;
  localparam int SHA_MSG_W = 1024;
  localparam int SHA_LEN_W = 128;
  localparam int SHA_HASH_W = 384;
  localparam logic [SHA_HASH_W-1:0] SHA256_MASK = {{(SHA_HASH_W-128){1'b1}}, 128'b0};
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_RESP
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: combinational one-hot pick of the first request at or after rr_ptr
module rr_arbiter_onehot #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  pick
);
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_first;
  logic [2*N-1:0] w_back;
  assign w_dbl   = {req, req} >> rr_ptr;
  assign w_rot   = w_dbl[N-1:0];
  assign w_first = w_rot & (~w_rot + N'(1));
  assign w_back  = {w_first, w_first} << rr_ptr;
  assign pick    = w_back[2*N-1:N];
endmodule

// File: rtl/sha_req_sched.sv
// sha_req_sched: round-robin sharing of one SHA engine between NUM_REQ requesters with a job watchdog
module sha_req_sched import sha_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TW = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_mode,
  input  logic [NUM_REQ*SHA_MSG_W-1:0]   req_msg,
  input  logic [NUM_REQ*SHA_LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [SHA_HASH_W-1:0]          rsp_hash,
  output logic                           rsp_err,
  output logic                           busy,
  output logic                           eng_run,
  output logic                           eng_mode,
  output logic [SHA_MSG_W-1:0]           eng_msg_in,
  output logic [SHA_LEN_W-1:0]           eng_msg_len,
  input  logic                           eng_ready,
  input  logic [SHA_HASH_W-1:0]          eng_hash_code
);
  localparam int PW = $clog2(NUM_REQ);
  sched_state_t r_state, w_next;
  logic [PW-1:0] r_rr_ptr, w_owner, w_nxt_ptr;
  logic [TW-1:0] r_cnt;
  logic [NUM_REQ-1:0] w_pick;
  logic w_timeout, w_done_ok;
  rr_arbiter_onehot #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req    (req_valid),
    .rr_ptr (r_rr_ptr),
    .pick   (w_pick)
  );
  always_comb begin
    eng_mode = 1'b0;
    eng_msg_in = '0;
    eng_msg_len = '0;
    w_owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        eng_mode = eng_mode | req_mode[i];
        eng_msg_in = eng_msg_in | req_msg[i*SHA_MSG_W +: SHA_MSG_W];
        eng_msg_len = eng_msg_len | req_len[i*SHA_LEN_W +: SHA_LEN_W];
        w_owner = PW'(i);
      end
    end
  end
  assign w_nxt_ptr = (w_owner == PW'(NUM_REQ-1)) ? '0 : w_owner + PW'(1);
  assign w_timeout = r_cnt == TW'(TIMEOUT_CYC-1);
  assign w_done_ok = (r_state == S_WAIT_DONE) && eng_ready;
  assign eng_run   = r_state == S_ISSUE;
  assign busy      = r_state != S_IDLE;
  assign rsp_valid = (r_state == S_RESP) ? grant : '0;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      w_next = (|req_valid && eng_ready) ? S_ISSUE : S_IDLE;
      S_ISSUE:     w_next = S_WAIT_ACC;
      S_WAIT_ACC:  w_next = !eng_ready ? S_WAIT_DONE : w_timeout ? S_RESP : S_WAIT_ACC;
      S_WAIT_DONE: w_next = (eng_ready || w_timeout) ? S_RESP : S_WAIT_DONE;
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      grant    <= '0;
      rsp_hash <= '0;
      rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state) ? r_cnt + TW'(1) : '0;
      if (r_state == S_IDLE && w_next == S_ISSUE) grant <= w_pick;
      if (r_state == S_ISSUE) rsp_err <= 1'b0;
      if (w_next == S_RESP) begin
        rsp_hash <= w_done_ok ? (eng_hash_code & (eng_mode ? '1 : SHA256_MASK)) : '0;
        rsp_err  <= !w_done_ok;
      end
      if (r_state == S_RESP) begin
        grant    <= '0;
        r_rr_ptr <= w_nxt_ptr;
      end
    end
  end
endmodule

// File: tb/tb_sha_req_sched.sv
// tb_sha_req_sched: randomized jobs against a transaction-level round-robin/latency model and a stub engine
module tb_sha_req_sched;
  localparam int N = 4;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_mode = '0;
  logic [N*1024-1:0] req_msg = '0;
  logic [N*128-1:0] req_len = '0;
  logic [N-1:0] grant, rsp_valid;
  logic [383:0] rsp_hash, eng_hash_code;
  logic rsp_err, busy, eng_run, eng_mode, eng_ready;
  logic [1023:0] eng_msg_in;
  logic [127:0] eng_msg_len;
  int n_checks = 0;
  int n_errors = 0;
  int m_ptr = 0;
  int runs = 0;
  int multi = 0;
  int rsp_cnt = 0;
  logic ext_busy = 1'b0;
  logic stub_accept = 1'b1;
  int stub_busy = 1;
  logic [383:0] stub_hash = '0;
  logic s_ready;
  int s_cnt;
  always #5 clk = ~clk;
  sha_req_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .TW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode),
    .req_msg(req_msg), .req_len(req_len), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_hash(rsp_hash), .rsp_err(rsp_err), .busy(busy), .eng_run(eng_run),
    .eng_mode(eng_mode), .eng_msg_in(eng_msg_in), .eng_msg_len(eng_msg_len),
    .eng_ready(eng_ready), .eng_hash_code(eng_hash_code)
  );
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready <= 1'b1;
      s_cnt <= 0;
    end else if (eng_run && stub_accept && stub_busy > 0) begin
      s_ready <= 1'b0;
      s_cnt <= stub_busy;
    end else if (s_cnt > 1) begin
      s_cnt <= s_cnt - 1;
    end else if (s_cnt == 1) begin
      s_cnt <= 0;
      s_ready <= 1'b1;
    end
  end
  assign eng_ready = s_ready && !ext_busy;
  assign eng_hash_code = s_ready ? stub_hash : {12{32'hdeadbeef}};
  always @(negedge clk) begin
    if (eng_run) runs++;
    if ($countones(grant) > 1) multi++;
    if (|rsp_valid) rsp_cnt++;
  end
  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int m_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  task automatic randomize_slots();
    for (int i = 0; i < N; i++) begin
      for (int w = 0; w < 32; w++) req_msg[i*1024 + w*32 +: 32] = $urandom;
      req_len[i*128 +: 128] = {96'h0, $urandom};
    end
  endtask
  task automatic do_job(input logic [N-1:0] vec, input int bsy, input logic acc,
                        input logic [N-1:0] modes, input logic drop, input int hold);
    int own, n, exp_n, r0, bad;
    logic to;
    logic [383:0] h, exp_h;
    logic [1023:0] msg;
    own = m_pick(vec, m_ptr);
    randomize_slots();
    req_mode = modes;
    for (int w = 0; w < 12; w++) h[w*32 +: 32] = $urandom;
    stub_hash = h;
    stub_busy = bsy;
    stub_accept = acc;
    ext_busy = hold > 0;
    req_valid = vec;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check("no_grant_while_engine_busy", 640'(grant), 640'(0));
      ext_busy = 1'b0;
    end
    n = 0;
    while (grant == '0 && n < 2000) begin @(posedge clk); #1; n++; end
    r0 = runs;
    msg = req_msg[own*1024 +: 1024];
    check("grant", 640'(grant), 640'(1 << own));
    check("eng_run_issue", 640'(eng_run), 640'(1));
    check("eng_msg_hi", 640'(eng_msg_in[1023:384]), 640'(msg[1023:384]));
    check("eng_msg_lo", 640'(eng_msg_in[383:0]), 640'(msg[383:0]));
    check("eng_msg_len", 640'(eng_msg_len), 640'(req_len[own*128 +: 128]));
    to = !acc || bsy > TO;
    exp_n = !acc ? TO + 1 : (bsy > TO ? TO + 2 : bsy + 2);
    exp_h = to ? '0 : (modes[own] ? h : {h[383:128], 128'h0});
    n = 0;
    bad = 0;
    while (rsp_valid == '0 && n < 3000) begin
      @(posedge clk); #1; n++;
      if (eng_mode !== modes[own] || grant !== N'(1 << own)) bad++;
      if (drop && n == 3) req_valid[own] = 1'b0;
    end
    check("latency", 640'(n), 640'(exp_n));
    check("rsp_valid", 640'(rsp_valid), 640'(1 << own));
    check("rsp_err", 640'(rsp_err), 640'(to));
    check("rsp_hash", 640'(rsp_hash), 640'(exp_h));
    check("grant_mode_hold", 640'(bad), 640'(0));
    m_ptr = (own + 1) % N;
    @(posedge clk); #1;
    check("rsp_single_pulse", 640'(rsp_valid), 640'(0));
    check("one_run_per_job", 640'(runs - r0), 640'(1));
    check("idle_after_resp", 640'(busy), 640'(0));
    check("mux_zero_idle", 640'(eng_msg_len), 640'(0));
  endtask
  task automatic reset_mid_job();
    int n, c0;
    randomize_slots();
    stub_busy = 300;
    stub_accept = 1'b1;
    req_valid = 4'b1010;
    n = 0;
    while (grant == '0 && n < 2000) begin @(posedge clk); #1; n++; end
    repeat (10) begin @(posedge clk); #1; end
    c0 = rsp_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("rst_grant", 640'(grant), 640'(0));
    check("rst_busy", 640'(busy), 640'(0));
    check("rst_eng_run", 640'(eng_run), 640'(0));
    check("rst_rsp_valid", 640'(rsp_valid), 640'(0));
    req_valid = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("no_rsp_for_lost_job", 640'(rsp_cnt - c0), 640'(0));
    m_ptr = 0;
  endtask
  initial begin
    randomize_slots();
    req_mode = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", 640'(grant), 640'(0));
    check("reset_rsp_valid", 640'(rsp_valid), 640'(0));
    check("reset_rsp_hash", 640'(rsp_hash), 640'(0));
    check("reset_rsp_err", 640'(rsp_err), 640'(0));
    check("reset_busy", 640'(busy), 640'(0));
    check("reset_eng_run", 640'(eng_run), 640'(0));
    check("reset_mux_msg", 640'(eng_msg_in[383:0]), 640'(0));
    check("reset_mux_mode", 640'(eng_mode), 640'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_job(4'b0001, 70, 1'b1, 4'b0000, 1'b0, 0);
    reset_mid_job();
    repeat (5) do_job(4'b1111, $urandom_range(1, 20), 1'b1, N'($urandom), 1'b0, 0);
    do_job(4'b0100, 20, 1'b1, N'($urandom), 1'b1, 0);
    do_job(4'b1111, 5, 1'b1, N'($urandom), 1'b0, 0);
    do_job(4'b0110, 5, 1'b0, N'($urandom), 1'b0, 0);
    do_job(N'($urandom_range(1, 15)), TO + 1, 1'b1, N'($urandom), 1'b0, 0);
    do_job(N'($urandom_range(1, 15)), TO, 1'b1, N'($urandom), 1'b0, 0);
    do_job(4'b1111, 30, 1'b1, 4'b1111, 1'b0, 0);
    do_job(N'($urandom_range(1, 15)), 10, 1'b1, N'($urandom), 1'b0, 4);
    repeat (2) do_job(4'b0010, 3, 1'b1, N'($urandom), 1'b0, 0);
    repeat (30) do_job(N'($urandom_range(1, 15)), $urandom_range(1, 40), 1'b1, N'($urandom),
                       1'($urandom_range(0, 1)), $urandom_range(0, 1) * $urandom_range(1, 3));
    check("grant_onehot", 640'(multi), 640'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
